// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous RAM between the CPU memory port
//   (requester 0) and the JTAG debug master (requester 1). One access is
//   granted per cycle under round-robin priority. The debug master can lock
//   the CPU out entirely. Read data arrives from the RAM one cycle after the
//   access and is steered back to whichever master issued the read. A
//   saturating counter records how many cycles both masters asked at once.
//
// Ports
//   CLK, RESET          clock and asynchronous active-high reset
//   REQn/WEn/ADDRn/BEn/WDATAn   request and payload from master n (held until GNTn)
//   GNTn                combinational grant to master n
//   RVALIDn/RDATAn      read return to master n (RDATA holds when not valid)
//   LOCK1               debug lock, keeps the CPU from being granted
//   RAM_*               strobe, write, address, byte enables and data to phy_mem
//   RAM_RDATA           read data from phy_mem, one cycle after a read strobe
//   CONFLICT_CNT/CNT_CLR  saturating contention counter and its sync clear

module mem_arbiter #(
  parameter int AW = 13,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RESET,

  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [3:0]    BE0,
  input  logic [31:0]   WDATA0,
  output logic          GNT0,
  output logic          RVALID0,
  output logic [31:0]   RDATA0,

  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [3:0]    BE1,
  input  logic [31:0]   WDATA1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic [31:0]   RDATA1,

  input  logic          LOCK1,

  output logic          RAM_EN,
  output logic          RAM_WE,
  output logic [AW-1:0] RAM_ADDR,
  output logic [3:0]    RAM_BE,
  output logic [31:0]   RAM_WDATA,
  input  logic [31:0]   RAM_RDATA,

  output logic [CW-1:0] CONFLICT_CNT,
  input  logic          CNT_CLR
);

  // Identifies a requester, used both for the round-robin pointer and for
  // the owner of an in-flight read.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } owner_e;

  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  owner_e        ptr_q,       ptr_d;
  logic          pendValid_q, pendValid_d;
  owner_e        pendOwner_q, pendOwner_d;
  logic [31:0]   rdata0_q,    rdata0_d;
  logic [31:0]   rdata1_q,    rdata1_d;
  logic [CW-1:0] cnt_q,       cnt_d;

  logic eligible0;
  logic eligible1;
  logic grant0;
  logic grant1;
  logic winnerWe;
  logic rvalid0;
  logic rvalid1;

  // Arbitration. The CPU is only a candidate while the debug lock is low;
  // the debug master is always a candidate. With a single candidate it wins
  // outright, with two the round-robin pointer decides, so the grants are
  // mutually exclusive by construction.
  always_comb begin
    eligible0 = REQ0 & ~LOCK1;
    eligible1 = REQ1;
    grant0    = eligible0 & (~eligible1 | (ptr_q == REQ_CPU));
    grant1    = eligible1 & (~eligible0 | (ptr_q == REQ_DBG));
  end

  assign GNT0 = grant0;
  assign GNT1 = grant1;

  // RAM request mux. The payload is taken straight from the winning master
  // (it is held stable until granted, so nothing is registered here). Byte
  // enables are zeroed on reads so the RAM never sees a stray write mask.
  always_comb begin
    RAM_EN    = 1'b0;
    RAM_WE    = 1'b0;
    RAM_ADDR  = '0;
    RAM_BE    = 4'b0000;
    RAM_WDATA = 32'h0;
    winnerWe  = 1'b0;
    if (grant0) begin
      RAM_EN    = 1'b1;
      RAM_WE    = WE0;
      RAM_ADDR  = ADDR0;
      RAM_BE    = WE0 ? BE0 : 4'b0000;
      RAM_WDATA = WDATA0;
      winnerWe  = WE0;
    end else if (grant1) begin
      RAM_EN    = 1'b1;
      RAM_WE    = WE1;
      RAM_ADDR  = ADDR1;
      RAM_BE    = WE1 ? BE1 : 4'b0000;
      RAM_WDATA = WDATA1;
      winnerWe  = WE1;
    end
  end

  // Next-state logic. The pointer hands priority to whichever master lost
  // this cycle and only moves on a grant, so a lock that starves the CPU
  // does not by itself shift priority. A granted read arms the pending
  // register with its owner; it drains by itself one cycle later, while the
  // next grant proceeds, which keeps throughput at one access per cycle.
  always_comb begin
    ptr_d       = ptr_q;
    pendValid_d = 1'b0;
    pendOwner_d = pendOwner_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    cnt_d       = cnt_q;

    if (grant0) begin
      ptr_d = REQ_DBG;
    end else if (grant1) begin
      ptr_d = REQ_CPU;
    end

    if ((grant0 | grant1) & ~winnerWe) begin
      pendValid_d = 1'b1;
      pendOwner_d = grant1 ? REQ_DBG : REQ_CPU;
    end

    if (rvalid0) begin
      rdata0_d = RAM_RDATA;
    end
    if (rvalid1) begin
      rdata1_d = RAM_RDATA;
    end

    // Clear wins over a simultaneous conflict; contention is judged on the
    // raw requests so cycles the lock hides from the CPU still count.
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (REQ0 & REQ1 & (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers. Reset drops any in-flight read so no RVALID can appear
  // for an access issued before reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_q       <= REQ_CPU;
      pendValid_q <= 1'b0;
      pendOwner_q <= REQ_CPU;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pendValid_q <= pendValid_d;
      pendOwner_q <= pendOwner_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      cnt_q       <= cnt_d;
    end
  end

  // Read return. The RAM data is passed through during the return cycle and
  // captured so the master keeps seeing it afterwards; the other master's
  // data register is left untouched.
  always_comb begin
    rvalid0 = pendValid_q & (pendOwner_q == REQ_CPU);
    rvalid1 = pendValid_q & (pendOwner_q == REQ_DBG);
  end

  assign RVALID0      = rvalid0;
  assign RVALID1      = rvalid1;
  assign RDATA0       = rvalid0 ? RAM_RDATA : rdata0_q;
  assign RDATA1       = rvalid1 ? RAM_RDATA : rdata1_q;
  assign CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A behavioural RAM stands in for phy_mem.
//   The stimulus process drives one cycle at a time and pushes each expected
//   read result into a per-master queue; a monitor pops and compares those
//   whenever the arbiter raises RVALID. Grants, RAM strobes and the counter
//   are compared against hand-computed constants in the stimulus.

module tb_mem_arbiter;

  localparam int AW = 13;
  localparam int CW = 4;

  logic          CLK;
  logic          RESET;
  logic          REQ0, WE0, REQ1, WE1, LOCK1, CNT_CLR;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [3:0]    BE0, BE1;
  logic [31:0]   WDATA0, WDATA1;
  logic          GNT0, GNT1, RVALID0, RVALID1;
  logic [31:0]   RDATA0, RDATA1;
  logic          RAM_EN, RAM_WE;
  logic [AW-1:0] RAM_ADDR;
  logic [3:0]    RAM_BE;
  logic [31:0]   RAM_WDATA, RAM_RDATA;
  logic [CW-1:0] CONFLICT_CNT;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] expQ0[$];
  logic [31:0] expQ1[$];

  logic [31:0] mem [0:(1<<AW)-1];

  mem_arbiter #(.AW(AW), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .BE0(BE0), .WDATA0(WDATA0),
    .GNT0(GNT0), .RVALID0(RVALID0), .RDATA0(RDATA0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .BE1(BE1), .WDATA1(WDATA1),
    .GNT1(GNT1), .RVALID1(RVALID1), .RDATA1(RDATA1),
    .LOCK1(LOCK1),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_BE(RAM_BE),
    .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA),
    .CONFLICT_CNT(CONFLICT_CNT), .CNT_CLR(CNT_CLR)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural single-port RAM: byte-masked writes, read data one cycle
  // after a read strobe.
  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) begin
        for (int b = 0; b < 4; b++) begin
          if (RAM_BE[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
        end
      end else begin
        RAM_RDATA <= mem[RAM_ADDR];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance to the next cycle, drive all master inputs, then let the
  // combinational grant path settle before any checks.
  task automatic applyStimulus(
    input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [3:0] b0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [3:0] b1, input logic [31:0] d1,
    input logic lock, input logic clr);
    @(posedge CLK);
    #1;
    REQ0 = r0; WE0 = w0; ADDR0 = a0; BE0 = b0; WDATA0 = d0;
    REQ1 = r1; WE1 = w1; ADDR1 = a1; BE1 = b1; WDATA1 = d1;
    LOCK1 = lock; CNT_CLR = clr;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, '0, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
  endtask

  // Scoreboard monitor: every RVALID must match the oldest expected read
  // for that master; an RVALID with nothing expected is itself a failure.
  always @(negedge CLK) begin
    if (RVALID0) begin
      if (expQ0.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rvalid0_unexpected: got RVALID0=1 data 0x%08h expected no return at %0t", RDATA0, $time);
      end else begin
        checkOutput("rdata0", RDATA0, expQ0.pop_front());
      end
    end
    if (RVALID1) begin
      if (expQ1.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rvalid1_unexpected: got RVALID1=1 data 0x%08h expected no return at %0t", RDATA1, $time);
      end else begin
        checkOutput("rdata1", RDATA1, expQ1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
    mem[5] <= 32'hDEADBEEF;
    mem[1] <= 32'h11111111;
    mem[2] <= 32'h22222222;
    mem[3] <= 32'h33333333;
    RAM_RDATA <= 32'h0;

    RESET = 1'b1;
    REQ0 = 0; WE0 = 0; ADDR0 = '0; BE0 = 0; WDATA0 = 0;
    REQ1 = 0; WE1 = 0; ADDR1 = '0; BE1 = 0; WDATA1 = 0;
    LOCK1 = 0; CNT_CLR = 0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    checkOutput("reset_rvalid0", {31'b0, RVALID0}, 32'd0);
    checkOutput("reset_rvalid1", {31'b0, RVALID1}, 32'd0);
    checkOutput("reset_cnt", {28'b0, CONFLICT_CNT}, 32'd0);
    checkOutput("reset_ram_en", {31'b0, RAM_EN}, 32'd0);

    // Single CPU read of 0x005; byte enables must be masked on a read.
    applyStimulus(1, 0, 13'h005, 4'hF, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
    checkOutput("rd5_gnt0", {31'b0, GNT0}, 32'd1);
    checkOutput("rd5_gnt1", {31'b0, GNT1}, 32'd0);
    checkOutput("rd5_ram_addr", {19'b0, RAM_ADDR}, 32'h005);
    checkOutput("rd5_ram_be", {28'b0, RAM_BE}, 32'h0);
    checkOutput("rd5_ram_we", {31'b0, RAM_WE}, 32'd0);
    expQ0.push_back(32'hDEADBEEF);
    idleCycle();
    checkOutput("rd5_rvalid0", {31'b0, RVALID0}, 32'd1);
    checkOutput("rd5_rvalid1", {31'b0, RVALID1}, 32'd0);

    // Fresh reset so the pointer and counter start from their reset values.
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Both masters write the same word for 4 cycles: order 0,1,0,1, and the
    // debug master's data is the last one to land.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 13'h020, 4'hF, 32'hAAAA0000, 1, 1, 13'h020, 4'hF, 32'hBBBB1111, 0, 0);
      checkOutput($sformatf("rr_gnt0_c%0d", k), {31'b0, GNT0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_gnt1_c%0d", k), {31'b0, GNT1}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    idleCycle();
    checkOutput("rr_cnt", {28'b0, CONFLICT_CNT}, 32'd4);

    // Debug lock: CPU read of 0x005 is starved for 3 cycles, then served.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 13'h005, 4'h0, 32'h0, 1, 1, 13'h030, 4'hF, 32'h0, 1, 0);
      checkOutput($sformatf("lock_gnt0_c%0d", k), {31'b0, GNT0}, 32'd0);
      checkOutput($sformatf("lock_gnt1_c%0d", k), {31'b0, GNT1}, 32'd1);
    end
    applyStimulus(1, 0, 13'h005, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
    checkOutput("unlock_gnt0", {31'b0, GNT0}, 32'd1);
    checkOutput("lock_cnt", {28'b0, CONFLICT_CNT}, 32'd7);
    expQ0.push_back(32'hDEADBEEF);

    // Debug partial write of 0x010, then CPU reads it back.
    applyStimulus(0, 0, '0, 4'h0, 32'h0, 1, 1, 13'h010, 4'b0011, 32'h12345678, 0, 0);
    checkOutput("dbgwr_gnt1", {31'b0, GNT1}, 32'd1);
    checkOutput("dbgwr_ram_be", {28'b0, RAM_BE}, 32'h3);
    checkOutput("dbgwr_ram_we", {31'b0, RAM_WE}, 32'd1);
    applyStimulus(1, 0, 13'h010, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
    checkOutput("rd10_gnt0", {31'b0, GNT0}, 32'd1);
    expQ0.push_back(32'h00005678);

    // Debug reads the contended word.
    applyStimulus(0, 0, '0, 4'h0, 32'h0, 1, 0, 13'h020, 4'h0, 32'h0, 0, 0);
    checkOutput("rd20_gnt1", {31'b0, GNT1}, 32'd1);
    expQ1.push_back(32'hBBBB1111);

    // Back-to-back CPU reads, one return per cycle in order.
    applyStimulus(1, 0, 13'h001, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
    checkOutput("b2b_gnt0_a", {31'b0, GNT0}, 32'd1);
    expQ0.push_back(32'h11111111);
    applyStimulus(1, 0, 13'h002, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
    checkOutput("b2b_gnt0_b", {31'b0, GNT0}, 32'd1);
    checkOutput("b2b_rvalid0_b", {31'b0, RVALID0}, 32'd1);
    expQ0.push_back(32'h22222222);
    applyStimulus(1, 0, 13'h003, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
    checkOutput("b2b_gnt0_c", {31'b0, GNT0}, 32'd1);
    checkOutput("b2b_rvalid0_c", {31'b0, RVALID0}, 32'd1);
    expQ0.push_back(32'h33333333);
    idleCycle();
    checkOutput("b2b_rvalid0_d", {31'b0, RVALID0}, 32'd1);
    checkOutput("b2b_rdata1_hold", RDATA1, 32'hBBBB1111);
    idleCycle();
    checkOutput("b2b_rvalid0_end", {31'b0, RVALID0}, 32'd0);

    // Reset right after a granted read: the return must be dropped.
    applyStimulus(1, 0, 13'h005, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0, 0, 0);
    checkOutput("rstrd_gnt0", {31'b0, GNT0}, 32'd1);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    REQ0 = 1'b0;
    #1;
    checkOutput("rstrd_rvalid0", {31'b0, RVALID0}, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Sustained conflict saturates the 4-bit counter; clear beats increment.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 1, 13'h030, 4'hF, 32'h0, 1, 1, 13'h030, 4'hF, 32'h0, 1, 0);
    end
    applyStimulus(1, 1, 13'h030, 4'hF, 32'h0, 1, 1, 13'h030, 4'hF, 32'h0, 1, 1);
    checkOutput("sat_cnt", {28'b0, CONFLICT_CNT}, 32'd15);
    idleCycle();
    checkOutput("clr_cnt", {28'b0, CONFLICT_CNT}, 32'd0);

    repeat (3) idleCycle();
    checkOutput("q0_drained", expQ0.size(), 32'd0);
    checkOutput("q1_drained", expQ1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data RAM between two masters: CPU memory port (requester 0) and JTAG debug master (requester 1).
- Grants one access per cycle using round-robin priority, with a debug lock that freezes CPU access.
- Routes the one-cycle-late read data back to the owning master.
- Keeps a saturating contention counter for debug visibility.
- Sits between the memory interface users and phy_mem.

Parameters:
- AW, 13, word-address width (RAM holds 2^AW 32-bit words).
- CW, 16, width of the contention counter.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ0  in  1  CPU request; held until GNT0.
- WE0  in  1  CPU write enable (0 = read).
- ADDR0  in  AW  CPU word address.
- BE0  in  4  CPU byte enables (writes only).
- WDATA0  in  32  CPU write data.
- GNT0  out  1  CPU request accepted this cycle.
- RVALID0  out  1  CPU read data valid.
- RDATA0  out  32  CPU read data.
- REQ1, WE1, ADDR1, BE1, WDATA1, GNT1, RVALID1, RDATA1: same as above, for the debug master.
- LOCK1  in  1  debug lock; while high, requester 0 is never granted.
- RAM_EN  out  1  RAM access strobe.
- RAM_WE  out  1  RAM write.
- RAM_ADDR  out  AW  RAM word address.
- RAM_BE  out  4  RAM byte enables.
- RAM_WDATA  out  32  RAM write data.
- RAM_RDATA  in  32  RAM read data, valid the cycle after RAM_EN with RAM_WE=0.
- CONFLICT_CNT  out  CW  count of cycles with REQ0 and REQ1 both high.
- CNT_CLR  in  1  synchronous clear of CONFLICT_CNT.

Behaviour:
- Reset values: RVALID0 = 0, RVALID1 = 0, CONFLICT_CNT = 0, priority pointer = requester 0, pending-read register empty. GNTx and RAM_* are combinational; they are 0 whenever no request is eligible.
- Eligibility: REQ1 is always eligible. REQ0 is eligible only when LOCK1 = 0.
- Arbitration (combinational, same cycle):
  - Only one requester eligible: that requester is granted.
  - Both eligible: the requester the pointer names is granted.
  - At most one GNT is high per cycle.
- Pointer update at each clock edge with a grant: the pointer moves to the requester not granted. No grant leaves the pointer unchanged.
- Granted cycle: RAM_EN = 1; RAM_WE, RAM_ADDR, RAM_BE and RAM_WDATA are taken from the winner. RAM_BE is forced to 0 on reads.
- Requester handshake:
  - REQx and its payload must stay stable until GNTx. The arbiter does not register the payload.
  - A requester may issue a new request the cycle after its GNT (back-to-back allowed).
- Read return:
  - A granted read sets a pending register (owner id).
  - On the next cycle, RVALIDowner = 1 for exactly one cycle and RDATAowner = RAM_RDATA.
  - RDATA of the non-owner is held at its last value.
  - A granted write produces no RVALID.
- Pipelining: a read granted in cycle N returns in N+1 while a new grant proceeds in N+1. Throughput is one access per cycle.
- Lock behaviour:
  - LOCK1 rising while REQ0 is waiting: GNT0 is withheld until LOCK1 falls.
  - A read already granted to requester 0 still returns its RVALID0.
  - The pointer is not modified by the lock itself.
- CONFLICT_CNT:
  - Increments each cycle REQ0 & REQ1 (raw, ignoring LOCK1) are both high.
  - Saturates at 2^CW-1.
  - CNT_CLR has priority over increment: the count reads 0 the next cycle.
- RESET asserted mid-transaction: pending read dropped, no RVALID emitted after reset. Grants continue to follow REQ combinationally during reset; the masters are required to hold REQ low while RESET is high.
- Simultaneous REQ0 and REQ1 with equal addresses, both writes: both are serviced in consecutive cycles in pointer order. The last-serviced write's data is what remains in RAM.

Test Plan:
- Reset, then REQ0 read at ADDR0 = 0x005 with RAM[5] = 0xDEADBEEF -> GNT0 same cycle; next cycle RVALID0 = 1 with RDATA0 = 0xDEADBEEF; RVALID1 stays 0.
- REQ0 and REQ1 both held high for 4 cycles from reset -> grant order 0,1,0,1; CONFLICT_CNT = 4 afterwards; exactly one GNT per cycle.
- LOCK1 = 1 with REQ0 and REQ1 high for 3 cycles -> GNT1 each cycle, GNT0 never. After LOCK1 = 0 with REQ0 still high -> GNT0 in that cycle.
- Write from debug (ADDR1 = 0x010, WDATA1 = 0x12345678, BE1 = 4'b0011), then CPU read of 0x010 with RAM initially 0 -> RAM_BE = 0011 on the write; RDATA0 = 0x00005678; no RVALID1.
- Back-to-back CPU reads 0x001, 0x002, 0x003 -> RVALID0 high for 3 consecutive cycles, data in order, one cycle after each grant.
- RESET asserted the cycle after a granted read -> RVALID0 stays 0. With CW = 4, sustained conflict for 20 cycles -> CONFLICT_CNT = 15; CNT_CLR -> 0.
